fetch_pair: RTL and testbench

Dual-width instruction fetch stage directly upstream of the instruction queue. Generates the fetch PC and issues one 64-bit (two-instruction) request at a time to instruction memory. Consults the branch predictor and delivers 0, 1 or 2 instructions per cycle, plus prediction info, on the queue's enqueue interface. Honours queue back-pressure and mispredict redirects, and discards stale in-flight responses.

---
 rtl/fetch_pair.sv | 191 +++++++++++++++++++
 tb/tb_fetch_pair.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_pair.sv
// -----------------------------------------------------------------------------
// fetch_pair: dual-width instruction fetch stage feeding the instruction queue.
//
// Generates the fetch PC and issues one 64-bit (two-instruction) request to
// instruction memory at a time. The branch predictor is consulted at request
// time to decide whether the fetched block yields one or two instructions and
// where fetch continues. The response is delivered to the queue as 0, 1 or 2
// instructions, with prediction info attached to a lone inst1. Handles queue
// back-pressure (a response is parked in a hold buffer) and backend redirects
// (any in-flight response becomes stale and is dropped on arrival).
//
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   imem_req/imem_addr       fetch request, 8-byte aligned address
//   imem_ready               memory accepts the request (req && ready)
//   imem_resp_valid/_data    in-order response, [31:0] @addr, [63:32] @addr+4
//   bp_hit0/bp_hit1          predictor entry present for fetch_pc / fetch_pc+4
//   bp_taken/bp_target       direction/target for the fetch_pc entry
//   iq_full                  queue cannot accept two instructions
//   mispredict/redirect_pc   backend redirect and corrected PC
//   inst{1,2}_in_valid       enqueue valids (one-cycle pulses)
//   inst{1,2}_in, _in_pc4    instruction words and their PC + 4
//   in_branch_valid          inst1 carries prediction info
//   in_btb_pc_predict        predicted target
//   in_direct_predict        predicted taken
// -----------------------------------------------------------------------------
module fetch_pair #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_resp_valid,
    input  logic [63:0] imem_resp_data,
    input  logic        bp_hit0,
    input  logic        bp_hit1,
    input  logic        bp_taken,
    input  logic [31:0] bp_target,
    input  logic        iq_full,
    input  logic        mispredict,
    input  logic [31:0] redirect_pc,
    output logic        inst1_in_valid,
    output logic        inst2_in_valid,
    output logic [31:0] inst1_in,
    output logic [31:0] inst2_in,
    output logic [31:0] inst1_in_pc4,
    output logic [31:0] inst2_in_pc4,
    output logic        in_branch_valid,
    output logic [31:0] in_btb_pc_predict,
    output logic        in_direct_predict
);

    typedef enum logic [1:0] {
        S_REQ,   // ready to issue a request
        S_WAIT,  // request outstanding
        S_HOLD   // response parked, waiting for queue space
    } state_t;

    // Per-request metadata captured at handshake, used when the data returns.
    typedef struct packed {
        logic        single;     // deliver inst1 only
        logic [31:0] pc;         // PC of the first delivered instruction
        logic        br_valid;
        logic [31:0] br_target;
        logic        br_taken;
    } slot_t;

    state_t      state;
    logic [31:0] fetch_pc;
    logic        discard;      // next response belongs to a squashed request
    logic        outstanding;  // a request has been accepted and not answered
    slot_t       slot;
    logic [63:0] hold_data;

    logic        handshake;
    logic        resp_accept;
    logic        deliver;
    slot_t       new_slot;
    logic [31:0] next_pc;
    logic [63:0] src_data;

    assign imem_addr   = {fetch_pc[31:3], 3'b000};
    assign imem_req    = !rst && (state == S_REQ) && !discard && !iq_full;
    assign handshake   = imem_req && imem_ready;
    // Responses with no request outstanding (e.g. after a reset) are ignored.
    assign resp_accept = imem_resp_valid && outstanding;

    // Enqueue happens straight from the memory response, or from the hold
    // buffer once the queue drains; a redirect squashes either.
    assign deliver  = !mispredict && !iq_full &&
                      (((state == S_WAIT) && resp_accept) || (state == S_HOLD));
    assign src_data = (state == S_HOLD) ? hold_data : imem_resp_data;

    // Slot decode and next fetch PC from the predictor lookup on fetch_pc.
    // A hit on the second word of an aligned block cuts the block short so
    // that the branch is refetched on its own and gets its own prediction.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        new_slot           = '0;
        new_slot.pc        = fetch_pc;
        new_slot.single    = fetch_pc[2] || bp_hit0 || bp_hit1;
        new_slot.br_valid  = bp_hit0;
        new_slot.br_target = bp_hit0 ? bp_target : 32'h0;
        new_slot.br_taken  = bp_hit0 && bp_taken;
        next_pc            = fetch_pc + 32'd8;
        if (bp_hit0 && bp_taken) begin
            next_pc = bp_target;
        end else if (new_slot.single) begin
            next_pc = fetch_pc + 32'd4;
        end
    end

    // NOTE: slot and hold_data are payload only, always qualified by state, so they carry no reset.
    always_ff @(posedge clk) begin
        if (handshake) begin
            slot <= new_slot;
        end
        if ((state == S_WAIT) && resp_accept) begin
            hold_data <= imem_resp_data;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            state             <= S_REQ;
            fetch_pc          <= RESET_PC;
            discard           <= 1'b0;
            outstanding       <= 1'b0;
            inst1_in_valid    <= 1'b0;
            inst2_in_valid    <= 1'b0;
            inst1_in          <= 32'h0;
            inst2_in          <= 32'h0;
            inst1_in_pc4      <= 32'h0;
            inst2_in_pc4      <= 32'h0;
            in_branch_valid   <= 1'b0;
            in_btb_pc_predict <= 32'h0;
            in_direct_predict <= 1'b0;
        end else begin
            if (handshake) begin
                outstanding <= 1'b1;
            end else if (resp_accept) begin
                outstanding <= 1'b0;
            end

            // Enqueue outputs are one-cycle pulses; fields are zero when idle.
            inst1_in_valid    <= deliver;
            inst2_in_valid    <= deliver && !slot.single;
            inst1_in          <= deliver ? (slot.pc[2] ? src_data[63:32] : src_data[31:0]) : 32'h0;
            inst2_in          <= (deliver && !slot.single) ? src_data[63:32] : 32'h0;
            inst1_in_pc4      <= deliver ? slot.pc + 32'd4 : 32'h0;
            inst2_in_pc4      <= (deliver && !slot.single) ? slot.pc + 32'd8 : 32'h0;
            in_branch_valid   <= deliver && slot.br_valid;
            in_btb_pc_predict <= (deliver && slot.br_valid) ? slot.br_target : 32'h0;
            in_direct_predict <= deliver && slot.br_taken;

            if (mispredict) begin
                fetch_pc <= redirect_pc;
                state    <= S_REQ;
                // A request still in flight after this edge must be dropped;
                // a response arriving right now is dropped here and needs no flag.
                discard  <= handshake || (outstanding && !imem_resp_valid);
            end else begin
                case (state)
                    S_REQ: begin
                        if (handshake) begin
                            fetch_pc <= next_pc;
                            state    <= S_WAIT;
                        end else if (resp_accept && discard) begin
                            discard <= 1'b0;
                        end
                    end
                    S_WAIT: begin
                        if (resp_accept) begin
                            state <= iq_full ? S_HOLD : S_REQ;
                        end
                    end
                    S_HOLD: begin
                        if (!iq_full) begin
                            state <= S_REQ;
                        end
                    end
                    default: state <= S_REQ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_pair.sv
// -----------------------------------------------------------------------------
// tb_fetch_pair: self-checking bench for fetch_pair.
//
// A behavioural model tracks the architectural fetch PC, the outstanding
// fetch, and a parked response. It predicts each delivery in terms of
// addresses (word at PC, word at PC+4) and pushes it into a scoreboard tagged
// with the cycle it must appear; an independent monitor compares DUT output
// against the scoreboard every cycle. Directed scenarios run first, then
// randomized traffic with random latency, back-pressure, hits and redirects.
// -----------------------------------------------------------------------------
module tb_fetch_pair;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_resp_valid;
    logic [63:0] imem_resp_data;
    logic        bp_hit0, bp_hit1, bp_taken;
    logic [31:0] bp_target;
    logic        iq_full;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic        inst1_in_valid, inst2_in_valid;
    logic [31:0] inst1_in, inst2_in, inst1_in_pc4, inst2_in_pc4;
    logic        in_branch_valid;
    logic [31:0] in_btb_pc_predict;
    logic        in_direct_predict;

    always #5 clk = ~clk;

    fetch_pair #(.RESET_PC(RESET_PC)) dut (
        .clk               (clk),
        .rst               (rst),
        .imem_req          (imem_req),
        .imem_addr         (imem_addr),
        .imem_ready        (imem_ready),
        .imem_resp_valid   (imem_resp_valid),
        .imem_resp_data    (imem_resp_data),
        .bp_hit0           (bp_hit0),
        .bp_hit1           (bp_hit1),
        .bp_taken          (bp_taken),
        .bp_target         (bp_target),
        .iq_full           (iq_full),
        .mispredict        (mispredict),
        .redirect_pc       (redirect_pc),
        .inst1_in_valid    (inst1_in_valid),
        .inst2_in_valid    (inst2_in_valid),
        .inst1_in          (inst1_in),
        .inst2_in          (inst2_in),
        .inst1_in_pc4      (inst1_in_pc4),
        .inst2_in_pc4      (inst2_in_pc4),
        .in_branch_valid   (in_branch_valid),
        .in_btb_pc_predict (in_btb_pc_predict),
        .in_direct_predict (in_direct_predict)
    );

    typedef struct {
        logic [31:0] i1;
        logic [31:0] i2;
        logic [31:0] pc4_1;
        logic [31:0] pc4_2;
        logic        v2;
        logic        br;
        logic [31:0] tgt;
        logic        tk;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    // Stimulus controls for the directed phase.
    logic        g_rst, g_rdy, g_full, g_misp;
    logic [31:0] g_rpc;
    bit          rand_mode = 1'b0;
    int          lat_lo = 1, lat_hi = 1;

    // Memory model.
    int          mem_cnt  = 0;
    logic [63:0] mem_data = '0;

    // Reference model state.
    logic [31:0] m_pc   = RESET_PC;
    logic        m_busy = 1'b0;  // memory owes a response to an accepted request
    logic        m_stale = 1'b0; // that response must be thrown away
    logic        m_held = 1'b0;  // a response is parked awaiting queue space
    exp_t        m_pend, m_hold;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input exp_t e);
        exp_t t;
        t     = e;
        t.due = cyc + 1;
        sb.push_back(t);
    endtask

    // One clock cycle of stimulus plus the model step for the coming edge.
    task automatic cycle();
        logic        exp_req, hs_d, hs_m, resp;
        logic        h0, h1, tk;
        logic [31:0] tgt;
        exp_t        it;
        @(negedge clk);
        #1;
        if (rand_mode) begin
            g_rst  = 1'b0;
            g_rdy  = ($urandom_range(0, 9) < 7);
            g_full = ($urandom_range(0, 9) < 2);
            g_misp = ($urandom_range(0, 19) == 0);
            g_rpc  = $urandom_range(0, 1023) * 4;
            h0     = ($urandom_range(0, 4) == 0);
            h1     = ($urandom_range(0, 4) == 0);
            tk     = $urandom_range(0, 1) == 1;
            tgt    = $urandom & 32'hFFFF_FFFC;
        end else begin
            // Directed predictor: one taken branch at 0x200 targeting 0x400.
            h0  = (m_pc == 32'h200);
            h1  = 1'b0;
            tk  = h0;
            tgt = 32'h400;
        end
        rst             = g_rst;
        imem_ready      = g_rdy;
        iq_full         = g_full;
        mispredict      = g_misp;
        redirect_pc     = g_rpc;
        bp_hit0         = h0;
        bp_hit1         = h1;
        bp_taken        = tk;
        bp_target       = tgt;
        imem_resp_valid = (mem_cnt == 1);
        imem_resp_data  = imem_resp_valid ? mem_data : {$urandom, $urandom};
        #1;
        exp_req = !g_rst && !m_busy && !m_held && !g_full;
        check("imem_req", imem_req, exp_req);
        if (exp_req) check("imem_addr", imem_addr, {m_pc[31:3], 3'b000});
        hs_d = imem_req && g_rdy;
        hs_m = exp_req && g_rdy;
        resp = imem_resp_valid && m_busy;

        if (mem_cnt > 0) mem_cnt--;
        if (hs_d) begin
            mem_cnt  = $urandom_range(lat_lo, lat_hi);
            mem_data = {$urandom, $urandom};
        end

        if (g_rst) begin
            m_pc    = RESET_PC;
            m_busy  = 1'b0;
            m_stale = 1'b0;
            m_held  = 1'b0;
        end else if (g_misp) begin
            m_held  = 1'b0;
            m_busy  = (m_busy && !resp) || hs_m;
            m_stale = m_busy;
            m_pc    = g_rpc;
        end else begin
            if (resp) begin
                m_busy = 1'b0;
                if (!m_stale) begin
                    if (g_full) begin
                        m_held = 1'b1;
                        m_hold = m_pend;
                    end else begin
                        push_exp(m_pend);
                    end
                end
                m_stale = 1'b0;
            end else if (m_held && !g_full) begin
                push_exp(m_hold);
                m_held = 1'b0;
            end
            if (hs_m) begin
                // Block yields one instruction if it starts mid-block or the
                // predictor knows about either word; otherwise both.
                it.v2    = !(m_pc[2] || h0 || h1);
                it.i1    = m_pc[2] ? mem_data[63:32] : mem_data[31:0];
                it.i2    = mem_data[63:32];
                it.pc4_1 = m_pc + 32'd4;
                it.pc4_2 = m_pc + 32'd8;
                it.br    = h0;
                it.tgt   = h0 ? tgt : 32'h0;
                it.tk    = h0 && tk;
                it.due   = 0;
                m_pend   = it;
                if (h0 && tk)  m_pc = tgt;
                else if (it.v2) m_pc = m_pc + 32'd8;
                else            m_pc = m_pc + 32'd4;
                m_busy  = 1'b1;
                m_stale = 1'b0;
            end
        end
    endtask

    task automatic wait_busy();
        for (int i = 0; i < 20 && !m_busy; i++) cycle();
        check("wait_for_handshake", m_busy, 1'b1);
    endtask

    task automatic check_reset_state();
        check("rst_imem_req", imem_req, 1'b0);
        check("rst_imem_addr", imem_addr, RESET_PC);
        check("rst_inst1_valid", inst1_in_valid, 1'b0);
        check("rst_inst2_valid", inst2_in_valid, 1'b0);
        check("rst_inst1", inst1_in, 32'h0);
        check("rst_inst1_pc4", inst1_in_pc4, 32'h0);
        check("rst_branch_valid", in_branch_valid, 1'b0);
        check("rst_btb_predict", in_btb_pc_predict, 32'h0);
        check("rst_direct_predict", in_direct_predict, 1'b0);
    endtask

    // Monitor: every cycle, compare enqueue outputs with the scoreboard.
    initial begin : monitor
        exp_t e;
        logic exp_v;
        forever begin
            @(negedge clk);
            exp_v = (sb.size() > 0) && (sb[0].due == cyc);
            if (exp_v) e = sb.pop_front();
            check("inst1_in_valid", inst1_in_valid, exp_v);
            check("inst2_in_valid", inst2_in_valid, exp_v && e.v2);
            if (exp_v) begin
                check("inst1_in", inst1_in, e.i1);
                check("inst1_in_pc4", inst1_in_pc4, e.pc4_1);
                check("in_branch_valid", in_branch_valid, e.br);
                check("in_btb_pc_predict", in_btb_pc_predict, e.tgt);
                check("in_direct_predict", in_direct_predict, e.tk);
                if (e.v2) begin
                    check("inst2_in", inst2_in, e.i2);
                    check("inst2_in_pc4", inst2_in_pc4, e.pc4_2);
                end
            end
        end
    end

    initial begin : stimulus
        g_rst = 1'b1; g_rdy = 1'b1; g_full = 1'b0; g_misp = 1'b0; g_rpc = '0;
        rst = 1'b1; imem_ready = 1'b0; iq_full = 1'b0; mispredict = 1'b0;
        redirect_pc = '0; bp_hit0 = 1'b0; bp_hit1 = 1'b0; bp_taken = 1'b0;
        bp_target = '0; imem_resp_valid = 1'b0; imem_resp_data = '0;

        // Reset state.
        repeat (3) cycle();
        check_reset_state();
        g_rst = 1'b0;

        // Back-to-back aligned pairs from RESET_PC.
        lat_lo = 1; lat_hi = 1;
        repeat (8) cycle();

        // Redirect to an unaligned PC: single from the upper word.
        g_misp = 1'b1; g_rpc = 32'h104; cycle(); g_misp = 1'b0;
        repeat (8) cycle();

        // Taken branch predicted at 0x200.
        g_misp = 1'b1; g_rpc = 32'h200; cycle(); g_misp = 1'b0;
        repeat (8) cycle();

        // Queue full when the response arrives: park, then release.
        lat_lo = 2; lat_hi = 2;
        wait_busy();
        g_full = 1'b1; repeat (4) cycle();
        g_full = 1'b0; repeat (4) cycle();

        // Redirect while a request is outstanding.
        lat_lo = 3; lat_hi = 3;
        wait_busy();
        cycle();
        g_misp = 1'b1; g_rpc = 32'h80; cycle(); g_misp = 1'b0;
        repeat (10) cycle();

        // Reset while a request is outstanding; the late response is ignored.
        lat_lo = 5; lat_hi = 5;
        wait_busy();
        g_full = 1'b1; cycle();
        g_rst = 1'b1; cycle(); cycle();
        check_reset_state();
        g_rst = 1'b0;
        repeat (4) cycle();
        g_full = 1'b0;
        lat_lo = 1; lat_hi = 1;
        repeat (6) cycle();

        // Randomized traffic.
        lat_lo = 1; lat_hi = 3;
        rand_mode = 1'b1;
        repeat (3000) cycle();
        rand_mode = 1'b0;

        // Drain.
        g_rst = 1'b0; g_rdy = 1'b1; g_full = 1'b0; g_misp = 1'b0;
        repeat (12) cycle();
        @(negedge clk);
        #2;
        check("scoreboard_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
